fetch_stage: RTL and testbench



---
 rtl/rv32i_pkg.sv | 23 ++
 rtl/fetch_stage_if.sv | 42 ++++
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/fetch_stage.sv | 111 +++++++++++
 tb/tb_fetch_stage.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// ============================================================================
// rv32i_pkg : shared rv32i widths, fetch constants and the fetch entry type
// Revision  : 1.0
// ============================================================================
`default_nettype none

package rv32i_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    // addi x0, x0, 0 -- substituted for the word of a faulting fetch
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic            fault;
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if.sv
// ============================================================================
// fetch_stage_if : imem request/response, redirect and decode handshake bundle
// Revision       : 1.0
// ============================================================================
`default_nettype none

interface fetch_stage_if;

    logic                         imem_req_valid;
    logic                         imem_req_ready;
    logic [rv32i_pkg::XLEN-1:0]   imem_req_addr;
    logic                         imem_rsp_valid;
    logic [rv32i_pkg::ILEN-1:0]   imem_rsp_data;
    logic                         imem_rsp_err;
    logic                         redirect_valid;
    logic [rv32i_pkg::XLEN-1:0]   redirect_pc;
    logic                         id_valid;
    logic                         id_ready;
    logic [rv32i_pkg::ILEN-1:0]   id_instr;
    logic [rv32i_pkg::XLEN-1:0]   id_pc;
    logic                         id_fault;

    // master is the fetch stage itself
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  redirect_valid, redirect_pc,
        output id_valid, id_instr, id_pc, id_fault,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output redirect_valid, redirect_pc,
        input  id_valid, id_instr, id_pc, id_fault,
        output id_ready
    );

endinterface

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo : small registered FIFO with push/pop/flush and occupancy count
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fetch_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [31:0]
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       push,
    input  wire T                           push_data,
    input  wire logic                       pop,
    input  wire logic                       flush,
    output T                                head,
    output logic [$clog2(DEPTH+1)-1:0]      count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            full;
    logic            empty;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && !empty;
    assign head    = mem[rd_ptr];

    // storage is cleared on reset so the head reads as zero until first push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(do_push && full));

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : rv32i PC owner, credit-limited imem fetch and decode FIFO
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_stage
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    fetch_stage_if.master bus
);

    localparam int             CW  = $clog2(DEPTH + 1);
    localparam logic [CW:0]    CAP = (CW + 1)'(DEPTH);

    logic [XLEN-1:0]  pc;
    logic [CW-1:0]    out_cnt;
    logic [CW-1:0]    drop_cnt;
    logic [CW-1:0]    fifo_cnt;
    logic [CW-1:0]    pcq_cnt;
    logic [XLEN-1:0]  pcq_head;
    fetch_entry_t     fifo_head;
    fetch_entry_t     rsp_entry;
    logic             credit_ok;
    logic             accept;
    logic             rsp;
    logic             rsp_keep;
    logic             redirect;
    logic             id_fire;

    assign redirect  = bus.redirect_valid;
    assign rsp       = bus.imem_rsp_valid;

    // credit covers in-flight requests (dropped ones included) plus buffered entries
    assign credit_ok = ({1'b0, out_cnt} + {1'b0, fifo_cnt}) < CAP;

    assign bus.imem_req_valid = rst_n && !redirect && credit_ok;
    assign bus.imem_req_addr  = pc;
    assign accept             = bus.imem_req_valid && bus.imem_req_ready;

    assign rsp_keep  = rsp && (drop_cnt == '0) && !redirect;
    assign rsp_entry = '{fault: bus.imem_rsp_err,
                         pc:    pcq_head,
                         instr: bus.imem_rsp_err ? NOP_INSTR : bus.imem_rsp_data};

    assign bus.id_valid = (fifo_cnt != '0) && !redirect;
    assign bus.id_instr = fifo_head.instr;
    assign bus.id_pc    = fifo_head.pc;
    assign bus.id_fault = fifo_head.fault;
    assign id_fire      = bus.id_valid && bus.id_ready;

    // PC queue is never flushed: pending drops still need their entries popped
    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (logic [XLEN-1:0])
    ) u_pc_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (pc),
        .pop       (rsp),
        .flush     (1'b0),
        .head      (pcq_head),
        .count     (pcq_cnt)
    );

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_entry_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_keep),
        .push_data (rsp_entry),
        .pop       (id_fire),
        .flush     (redirect),
        .head      (fifo_head),
        .count     (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else if (redirect) begin
            pc       <= bus.redirect_pc & ~XLEN'(3);
            out_cnt  <= out_cnt - CW'(rsp);
            drop_cnt <= out_cnt - CW'(rsp);
        end else begin
            if (accept) begin
                pc <= pc + XLEN'(4);
            end
            out_cnt <= out_cnt + CW'(accept) - CW'(rsp);
            if (rsp && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    a_pcq_tracks_outstanding : assert property (@(posedge clk) disable iff (!rst_n)
        pcq_cnt == out_cnt);

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage : randomized scoreboard bench for fetch_stage
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;
    import rv32i_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC (RST_PC),
        .DEPTH    (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int           total = 0;
    int           bad = 0;
    int           delivered = 0;
    int           faults_seen = 0;
    int           mem_lat = 1;
    fetch_entry_t exp_q[$];
    logic [31:0]  gen_pc = '0;
    logic [31:0]  req_exp = '0;
    logic         last_redir = 1'b0;
    logic [31:0]  last_tgt = '0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic fault_of(input logic [31:0] a);
        return a[6:0] == 7'h08;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // expected decode stream: consecutive words from the latest start address
    task automatic refill();
        fetch_entry_t e;
        while (exp_q.size() < 16) begin
            e.pc    = gen_pc;
            e.fault = fault_of(gen_pc);
            e.instr = e.fault ? NOP_INSTR : instr_of(gen_pc);
            exp_q.push_back(e);
            gen_pc = gen_pc + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] base);
        exp_q.delete();
        gen_pc  = base;
        req_exp = base;
        refill();
    endtask

    // memory model: in-order responses, latency mem_lat (0 = random 1..4)
    logic [31:0] pend_a[$];
    int          pend_due[$];
    int          mcyc = 0;
    int          last_due = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;

    initial begin : mem_model
        logic [31:0] a;
        int          lat;
        int          due;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            mcyc++;
            if (pend_a.size() > 0 && pend_due[0] <= mcyc) begin
                a = pend_a.pop_front();
                void'(pend_due.pop_front());
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = instr_of(a);
                bus.imem_rsp_err   = fault_of(a);
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = $urandom;
                bus.imem_rsp_err   = 1'($urandom % 2);
            end
            #2;
            if (!rst_n) begin
                pend_a.delete();
                pend_due.delete();
                last_due   = 0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && bus.imem_req_valid)
                    chk("req_addr_stable", bus.imem_req_addr, prev_addr);
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    chk("req_addr", bus.imem_req_addr, req_exp);
                    req_exp = req_exp + 32'd4;
                    lat = (mem_lat > 0) ? mem_lat : int'($urandom_range(1, 4));
                    due = mcyc + lat;
                    if (due <= last_due) due = last_due + 1;
                    pend_a.push_back(bus.imem_req_addr);
                    pend_due.push_back(due);
                    last_due = due;
                end
                prev_stall = bus.imem_req_valid && !bus.imem_req_ready;
                prev_addr  = bus.imem_req_addr;
            end
        end
    end

    initial begin : monitor
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && bus.id_valid && bus.id_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL id_unexpected: got pc %h, nothing expected", bus.id_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("id_pc", bus.id_pc, e.pc);
                    chk("id_instr", bus.id_instr, e.instr);
                    chk("id_fault", 32'(bus.id_fault), 32'(e.fault));
                    delivered++;
                    if (bus.id_fault) faults_seen++;
                end
            end
        end
    end

    task automatic step(input logic rdy, input logic idr, input logic redir, input logic [31:0] tgt);
        @(negedge clk);
        bus.imem_req_ready = rdy;
        bus.id_ready       = idr;
        bus.redirect_valid = redir;
        bus.redirect_pc    = redir ? tgt : $urandom;
        if (redir) restart(tgt & ~32'h3);
        refill();
        #1;
        if (redir) begin
            chk("redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
            chk("redir_id_valid", 32'(bus.id_valid), 32'd0);
        end
        if (last_redir) chk("redir_next_addr", bus.imem_req_addr, last_tgt);
        last_redir = redir;
        last_tgt   = tgt & ~32'h3;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        restart(RST_PC);
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
        chk("rst_id_instr", bus.id_instr, 32'd0);
        chk("rst_id_pc", bus.id_pc, 32'd0);
        chk("rst_id_fault", 32'(bus.id_fault), 32'd0);
        chk("rst_req_addr", bus.imem_req_addr, RST_PC);
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("rel_req_addr", bus.imem_req_addr, RST_PC);
        last_redir = 1'b0;
    endtask

    initial begin : stimulus
        int   acc;
        logic seen8;
        bus.imem_req_ready = 1'b1;
        bus.id_ready       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        // streaming from reset, first delivery two cycles after first accept
        mem_lat = 1;
        reset_dut();
        step(1'b1, 1'b1, 1'b0, '0);
        chk("first_id_valid_early", 32'(bus.id_valid), 32'd0);
        step(1'b1, 1'b1, 1'b0, '0);
        chk("first_id_valid", 32'(bus.id_valid), 32'd1);
        chk("first_id_pc", bus.id_pc, RST_PC);
        seen8 = 1'b0;
        repeat (20) begin
            step(1'b1, 1'b1, 1'b0, '0);
            if (bus.id_valid && bus.id_pc == 32'd8) begin
                seen8 = 1'b1;
                chk("pc8_fault", 32'(bus.id_fault), 32'd1);
                chk("pc8_nop", bus.id_instr, 32'h0000_0013);
            end
        end
        chk("pc8_seen", 32'(seen8), 32'd1);

        // decode stalled: credit caps the number of requests
        bus.id_ready = 1'b0;
        reset_dut();
        acc = (bus.imem_req_valid && bus.imem_req_ready) ? 1 : 0;
        repeat (9) begin
            step(1'b1, 1'b0, 1'b0, '0);
            if (bus.imem_req_valid && bus.imem_req_ready) acc++;
        end
        chk("stall_accepts_le2", 32'(acc <= 2), 32'd1);
        chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("stall_id_valid", 32'(bus.id_valid), 32'd1);
        chk("stall_id_pc", bus.id_pc, RST_PC);
        repeat (10) step(1'b1, 1'b1, 1'b0, '0);

        // memory not ready: request held stable
        bus.imem_req_ready = 1'b0;
        bus.id_ready       = 1'b1;
        reset_dut();
        repeat (5) begin
            step(1'b0, 1'b1, 1'b0, '0);
            chk("hold_req_valid", 32'(bus.imem_req_valid), 32'd1);
            chk("hold_req_addr", bus.imem_req_addr, RST_PC);
        end
        repeat (10) step(1'b1, 1'b1, 1'b0, '0);

        // redirect with two requests in flight
        mem_lat            = 3;
        bus.imem_req_ready = 1'b1;
        reset_dut();
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        step(1'b1, 1'b1, 1'b0, '0);
        chk("redir_addr_100", bus.imem_req_addr, 32'h0000_0100);
        repeat (20) step(1'b1, 1'b1, 1'b0, '0);

        // reset with a full FIFO
        mem_lat      = 1;
        bus.id_ready = 1'b0;
        reset_dut();
        repeat (6) step(1'b1, 1'b0, 1'b0, '0);
        chk("full_id_valid", 32'(bus.id_valid), 32'd1);
        reset_dut();
        repeat (10) step(1'b1, 1'b1, 1'b0, '0);

        // randomized traffic with redirects (some near the address wrap)
        mem_lat = 0;
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom % 8 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 25) == 0, tgt);
        end
        repeat (10) step(1'b1, 1'b1, 1'b0, '0);

        chk("delivered_many", 32'(delivered > 300), 32'd1);
        chk("faults_seen", 32'(faults_seen > 0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
